// File: rtl/train_sched.sv
// Training-request scheduler for cont_mem: queues {hv, label} requests and issues them one at a time.
// Latency: cm_en pulses on the edge after a request reaches the head of a non-empty queue with the FSM idle and cm_done high.
// Backpressure: in_ready = queue not full and no flush; only one request is in flight, waiting on a cm_done low-then-high handshake.
//
// Ports:
//   clk, nrst                       clock, async active-low reset
//   in_valid/in_ready/in_hv/in_label request handshake and payload
//   flush                           drop every queued, un-issued request
//   cm_en/cm_hv_train/cm_label      issue pulse and held payload to cont_mem
//   cm_done                         cont_mem completion level
//   busy                            queue non-empty or request in flight
//   count_nonseizure/count_seizure  saturating completed-update counters
module train_sched #(
  parameter int DIMENSIONS = 10000,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIMENSIONS-1:0] in_hv,
  input  logic                  in_label,
  input  logic                  flush,
  output logic                  cm_en,
  output logic [DIMENSIONS-1:0] cm_hv_train,
  output logic                  cm_label,
  input  logic                  cm_done,
  output logic                  busy,
  output logic [CNT_W-1:0]      count_nonseizure,
  output logic [CNT_W-1:0]      count_seizure
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] ST_STARTUP   = 2'd0;
  localparam logic [1:0] ST_IDLE      = 2'd1;
  localparam logic [1:0] ST_WAIT_LOW  = 2'd2;
  localparam logic [1:0] ST_WAIT_HIGH = 2'd3;

  logic [1:0]            r_state;
  logic [AW:0]           r_wr_ptr;
  logic [AW:0]           r_rd_ptr;
  logic [DIMENSIONS-1:0] r_hv_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_lbl_mem;
  logic                  r_cm_en;
  logic [DIMENSIONS-1:0] r_cm_hv;
  logic                  r_cm_label;
  logic [CNT_W-1:0]      r_cnt0;
  logic [CNT_W-1:0]      r_cnt1;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_issue;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign in_ready = !w_full && !flush;
  assign w_push   = in_valid && in_ready;
  // Issue needs cont_mem idle (cm_done high); flush blocks it so the flushed head is never sent.
  assign w_issue  = (r_state == ST_IDLE) && !w_empty && cm_done && !flush;

  // Queue storage
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_hv_mem[i] <= '0;
      end
      r_lbl_mem <= '0;
    end else if (w_push) begin
      r_hv_mem[r_wr_ptr[AW-1:0]]  <= in_hv;
      r_lbl_mem[r_wr_ptr[AW-1:0]] <= in_label;
    end
  end

  // Queue pointers; push is impossible during flush because in_ready is low.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_rd_ptr <= r_wr_ptr;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
    end
  end

  // Issue / completion FSM
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state    <= ST_STARTUP;
      r_cm_en    <= 1'b0;
      r_cm_hv    <= '0;
      r_cm_label <= 1'b0;
      r_cnt0     <= '0;
      r_cnt1     <= '0;
    end else begin
      r_cm_en <= 1'b0;
      case (r_state)
        // cont_mem ignores en during its own startup cycle, so never issue here.
        ST_STARTUP: r_state <= ST_IDLE;
        ST_IDLE: begin
          if (w_issue) begin
            r_cm_hv    <= r_hv_mem[r_rd_ptr[AW-1:0]];
            r_cm_label <= r_lbl_mem[r_rd_ptr[AW-1:0]];
            r_cm_en    <= 1'b1;
            r_state    <= ST_WAIT_LOW;
          end
        end
        ST_WAIT_LOW: begin
          if (!cm_done) begin
            r_state <= ST_WAIT_HIGH;
          end
        end
        ST_WAIT_HIGH: begin
          // Payload stays held until here: cont_mem re-samples the label at completion.
          if (cm_done) begin
            if (r_cm_label) begin
              if (r_cnt1 != {CNT_W{1'b1}}) begin
                r_cnt1 <= r_cnt1 + CNT_W'(1);
              end
            end else begin
              if (r_cnt0 != {CNT_W{1'b1}}) begin
                r_cnt0 <= r_cnt0 + CNT_W'(1);
              end
            end
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cm_en            = r_cm_en;
  assign cm_hv_train      = r_cm_hv;
  assign cm_label         = r_cm_label;
  assign count_nonseizure = r_cnt0;
  assign count_seizure    = r_cnt1;
  assign busy             = !w_empty || (r_state == ST_WAIT_LOW) || (r_state == ST_WAIT_HIGH);

endmodule
